// File: rtl/idli_fetch_m_if.sv
// idli_fetch_m_if -- bus bundle between the instruction fetch unit, the SQI
// controller and the decoder.
//
// Signals (direction as seen from the fetch unit):
//   o_sqi_ctr[1:0]        cycle index within the current 4-cycle period
//   o_sqi_ctr_last_cycle  high on cycle 3 of each period
//   o_sqi_redirect        request to restart the SQI transaction
//   o_sqi_rd              transaction type, always read
//   o_sqi_wr_data[3:0]    fetch address nibble to the SQI controller
//   o_sqi_wr_data_vld     o_sqi_wr_data valid
//   i_sqi_rd_data[3:0]    read nibble from the SQI controller
//   i_redirect            core branch/redirect request
//   i_redirect_pc[15:0]   redirect target word address
//   o_instr_vld           instruction available
//   i_instr_rdy           decoder accepts instruction
//   o_instr[15:0]         instruction word
//   o_instr_pc[15:0]      word address of o_instr
//
// Modports: master = fetch unit, slave = SQI controller / core side.
interface idli_fetch_m_if;
  logic [1:0]  o_sqi_ctr;
  logic        o_sqi_ctr_last_cycle;
  logic        o_sqi_redirect;
  logic        o_sqi_rd;
  logic [3:0]  o_sqi_wr_data;
  logic        o_sqi_wr_data_vld;
  logic [3:0]  i_sqi_rd_data;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_instr_vld;
  logic        i_instr_rdy;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;

  modport master (
    output o_sqi_ctr, o_sqi_ctr_last_cycle, o_sqi_redirect, o_sqi_rd,
    output o_sqi_wr_data, o_sqi_wr_data_vld, o_instr_vld, o_instr, o_instr_pc,
    input  i_sqi_rd_data, i_redirect, i_redirect_pc, i_instr_rdy
  );

  modport slave (
    input  o_sqi_ctr, o_sqi_ctr_last_cycle, o_sqi_redirect, o_sqi_rd,
    input  o_sqi_wr_data, o_sqi_wr_data_vld, o_instr_vld, o_instr, o_instr_pc,
    output i_sqi_rd_data, i_redirect, i_redirect_pc, i_instr_rdy
  );
endinterface

// File: rtl/idli_fetch_m.sv
// idli_fetch_m -- instruction fetch unit streaming 16-bit words from a quad
// SPI memory, one nibble per cycle, into a 2-entry instruction buffer.
//
// Ports:
//   i_sqi_gck    clock, all state changes on the rising edge
//   i_sqi_rst_n  asynchronous active-low reset
//   bus          idli_fetch_m_if.master (SQI address/data, redirect,
//                instruction valid/ready handshake)
//
// Each 4-cycle period is one phase of the SQI transaction:
// INIT (address out) -> ADDR -> DUMMY -> DATA, then DATA repeats until a
// restart is requested. Read data lags the memory by one period, so a word
// is captured in the period following a DATA period.
module idli_fetch_m (
  input  logic          i_sqi_gck,
  input  logic          i_sqi_rst_n,
  idli_fetch_m_if.master bus
);

  typedef enum logic [1:0] {PH_INIT, PH_ADDR, PH_DUMMY, PH_DATA} phase_t;

  phase_t      phase;
  logic [1:0]  ctr;
  logic [15:0] fetch_addr;
  logic [15:0] stream_pc;
  logic        redirect_pending;
  logic        capture;
  logic [11:0] word_lo;

  logic [31:0] fifo_q [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;

  logic        last_cycle;
  logic [15:0] word_full;
  logic        complete;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        overflow;
  logic [3:0]  wr_nibble;

  // The last nibble of a word is used straight off the bus so the word can
  // be pushed in the same cycle it completes.
  always_comb begin
    last_cycle = (ctr == 2'd3);
    word_full  = {bus.i_sqi_rd_data, word_lo};
    complete   = last_cycle && capture && !redirect_pending;
    fifo_empty = (fifo_cnt == 2'd0);
    fifo_full  = (fifo_cnt == 2'd2);
    pop        = !fifo_empty && bus.i_instr_rdy;
    push       = complete && (!fifo_full || pop);
    overflow   = complete && fifo_full && !pop;
  end

  always_comb begin
    wr_nibble = 4'h0;
    if (phase == PH_INIT) begin
      case (ctr)
        2'd0:    wr_nibble = fetch_addr[3:0];
        2'd1:    wr_nibble = fetch_addr[7:4];
        2'd2:    wr_nibble = fetch_addr[11:8];
        default: wr_nibble = fetch_addr[15:12];
      endcase
    end
  end

  // Phase sequencing, stream address tracking and restart requests.
  // A dropped word (buffer full) restarts the stream at that word's address;
  // a core redirect takes precedence over that.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      phase            <= PH_INIT;
      ctr              <= 2'd0;
      fetch_addr       <= 16'h0000;
      stream_pc        <= 16'h0000;
      redirect_pending <= 1'b0;
      capture          <= 1'b0;
      word_lo          <= 12'h000;
    end else begin
      ctr <= ctr + 2'd1;

      case (ctr)
        2'd0:    word_lo[3:0]  <= bus.i_sqi_rd_data;
        2'd1:    word_lo[7:4]  <= bus.i_sqi_rd_data;
        2'd2:    word_lo[11:8] <= bus.i_sqi_rd_data;
        default: ;
      endcase

      if (complete) begin
        stream_pc <= stream_pc + 16'd1;
      end

      if (last_cycle) begin
        // Next period carries data only if this DATA period is not the end
        // of the transaction.
        capture <= (phase == PH_DATA) && !redirect_pending;
        case (phase)
          PH_INIT: begin
            phase     <= PH_ADDR;
            stream_pc <= fetch_addr;
          end
          PH_ADDR:  phase <= PH_DUMMY;
          PH_DUMMY: phase <= PH_DATA;
          default:  if (redirect_pending) phase <= PH_INIT;
        endcase
      end

      if (bus.i_redirect) begin
        fetch_addr       <= bus.i_redirect_pc;
        redirect_pending <= 1'b1;
      end else if (overflow) begin
        fetch_addr       <= stream_pc;
        redirect_pending <= 1'b1;
      end else if (last_cycle && (phase == PH_DATA) && redirect_pending) begin
        redirect_pending <= 1'b0;
      end
    end
  end

  // Two-entry instruction buffer. When full, a pop frees the head slot which
  // the write pointer is aimed at, so a simultaneous push lands safely.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      fifo_q[0] <= 32'h0;
      fifo_q[1] <= 32'h0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
    end else if (bus.i_redirect) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= {stream_pc, word_full};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.o_sqi_ctr            = ctr;
  assign bus.o_sqi_ctr_last_cycle = last_cycle;
  assign bus.o_sqi_redirect       = redirect_pending;
  assign bus.o_sqi_rd             = 1'b1;
  assign bus.o_sqi_wr_data        = wr_nibble;
  assign bus.o_sqi_wr_data_vld    = (phase == PH_INIT);
  assign bus.o_instr_vld          = !fifo_empty;
  assign bus.o_instr_pc           = fifo_empty ? 16'h0000 : fifo_q[rd_ptr][31:16];
  assign bus.o_instr              = fifo_empty ? 16'h0000 : fifo_q[rd_ptr][15:0];

endmodule

// File: tb/tb_idli_fetch_m.sv
// tb_idli_fetch_m -- self-checking bench for idli_fetch_m.
// Contains a behavioural SQI memory that collects the address nibbles and
// returns consecutive words one period late, a table of per-cycle vectors for
// the first fetch, and directed sequences for backpressure, redirects,
// address wrap and mid-run reset.
module tb_idli_fetch_m;

  logic i_sqi_gck   = 1'b0;
  logic i_sqi_rst_n = 1'b0;

  idli_fetch_m_if bus();

  idli_fetch_m dut (
    .i_sqi_gck  (i_sqi_gck),
    .i_sqi_rst_n(i_sqi_rst_n),
    .bus        (bus)
  );

  always #5 i_sqi_gck = ~i_sqi_gck;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  logic [15:0] mem [0:65535];

  logic [15:0] pop_pc[$];
  logic [15:0] pop_word[$];
  int          pop_cyc[$];

  // SQI memory model, evaluated mid-cycle: t counts cycles since the start
  // of the current address phase; period p>=4 returns word addr+(p-4).
  int          m_t       = 0;
  logic [15:0] m_addr_sh = 16'h0;
  logic [15:0] m_addr    = 16'h0;

  always @(negedge i_sqi_gck) begin : sqi_model
    int          t;
    int          p;
    logic [15:0] sh;
    logic [15:0] a;
    logic [15:0] idx;
    logic [15:0] w;
    t  = (bus.o_sqi_wr_data_vld && bus.o_sqi_ctr == 2'd0) ? 0 : m_t + 1;
    sh = m_addr_sh;
    a  = m_addr;
    if (bus.o_sqi_wr_data_vld) begin
      sh[4*bus.o_sqi_ctr +: 4] = bus.o_sqi_wr_data;
      if (bus.o_sqi_ctr == 2'd3) a = sh;
    end
    p = t / 4;
    if (p >= 4) begin
      idx = a + 16'(p - 4);
      w   = mem[idx];
      bus.i_sqi_rd_data <= w[4*(t%4) +: 4];
    end else begin
      bus.i_sqi_rd_data <= 4'($urandom);
    end
    m_t       <= t;
    m_addr_sh <= sh;
    m_addr    <= a;
  end

  typedef struct {
    int          cyc;
    logic        rdy;
    logic [1:0]  ctr;
    logic        last;
    logic        redir;
    logic        wr_vld;
    logic [3:0]  wr_data;
    logic        ivld;
    logic [15:0] instr;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs[10];

  task automatic applyStimulus(input logic rdy, input logic redir, input logic [15:0] rpc);
    bus.i_instr_rdy   = rdy;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkPop(input string name, input int i, input logic [15:0] exp_pc,
                          input logic [15:0] exp_word);
    if (i < pop_pc.size()) begin
      checkOutput({name, "_pc"}, {16'h0, pop_pc[i]}, {16'h0, exp_pc});
      checkOutput({name, "_word"}, {16'h0, pop_word[i]}, {16'h0, exp_word});
    end else begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: only %0d words delivered, expected index %0d", name,
               pop_pc.size(), i);
    end
  endtask

  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(negedge i_sqi_gck);
      cyc++;
    end
  endtask

  task automatic runCycles(input int end_cyc);
    while (cyc < end_cyc) begin
      if (bus.o_instr_vld && bus.i_instr_rdy) begin
        pop_pc.push_back(bus.o_instr_pc);
        pop_word.push_back(bus.o_instr);
        pop_cyc.push_back(cyc);
      end
      @(negedge i_sqi_gck);
      cyc++;
    end
  endtask

  task automatic doReset(input logic rdy);
    i_sqi_rst_n = 1'b0;
    applyStimulus(rdy, 1'b0, 16'h0);
    repeat (3) @(negedge i_sqi_gck);
    i_sqi_rst_n = 1'b1;
    cyc = 0;
    pop_pc.delete();
    pop_word.delete();
    pop_cyc.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    bus.i_sqi_rd_data = 4'h0;
    applyStimulus(1'b0, 1'b0, 16'h0);

    //            cyc rdy ctr  last redir wvld wdata ivld instr     pc
    vecs[0] = '{ 0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{ 1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{ 2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{ 3, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{ 4, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{16, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{19, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[7] = '{20, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 16'h1234, 16'h0000};
    vecs[8] = '{21, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 16'h0000};
    vecs[9] = '{24, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 16'h5678, 16'h0001};

    // First fetch from address 0 checked cycle by cycle.
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    @(negedge i_sqi_gck);
    doReset(1'b1);
    for (int i = 0; i < 10; i++) begin
      stepTo(vecs[i].cyc);
      applyStimulus(vecs[i].rdy, 1'b0, 16'h0);
      checkOutput($sformatf("t1_c%0d_ctr", vecs[i].cyc), {30'h0, bus.o_sqi_ctr}, {30'h0, vecs[i].ctr});
      checkOutput($sformatf("t1_c%0d_last", vecs[i].cyc), {31'h0, bus.o_sqi_ctr_last_cycle}, {31'h0, vecs[i].last});
      checkOutput($sformatf("t1_c%0d_redir", vecs[i].cyc), {31'h0, bus.o_sqi_redirect}, {31'h0, vecs[i].redir});
      checkOutput($sformatf("t1_c%0d_rd", vecs[i].cyc), {31'h0, bus.o_sqi_rd}, 32'h1);
      checkOutput($sformatf("t1_c%0d_wvld", vecs[i].cyc), {31'h0, bus.o_sqi_wr_data_vld}, {31'h0, vecs[i].wr_vld});
      if (vecs[i].wr_vld)
        checkOutput($sformatf("t1_c%0d_wdata", vecs[i].cyc), {28'h0, bus.o_sqi_wr_data}, {28'h0, vecs[i].wr_data});
      checkOutput($sformatf("t1_c%0d_ivld", vecs[i].cyc), {31'h0, bus.o_instr_vld}, {31'h0, vecs[i].ivld});
      if (vecs[i].ivld || vecs[i].cyc == 0) begin
        checkOutput($sformatf("t1_c%0d_instr", vecs[i].cyc), {16'h0, bus.o_instr}, {16'h0, vecs[i].instr});
        checkOutput($sformatf("t1_c%0d_pc", vecs[i].cyc), {16'h0, bus.o_instr_pc}, {16'h0, vecs[i].pc});
      end
    end

    // Streaming: four words, one every four cycles.
    mem[0] = 16'hA001; mem[1] = 16'hA002; mem[2] = 16'hA003; mem[3] = 16'hA004;
    doReset(1'b1);
    runCycles(40);
    checkPop("t2_w0", 0, 16'h0000, 16'hA001);
    checkPop("t2_w1", 1, 16'h0001, 16'hA002);
    checkPop("t2_w2", 2, 16'h0002, 16'hA003);
    checkPop("t2_w3", 3, 16'h0003, 16'hA004);
    if (pop_cyc.size() >= 4) begin
      checkOutput("t2_first_cyc", pop_cyc[0], 20);
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("t2_gap%0d", i), pop_cyc[i+1] - pop_cyc[i], 4);
    end

    // Backpressure: third word overflows and is refetched.
    mem[0] = 16'hB000; mem[1] = 16'hB001; mem[2] = 16'hB002; mem[3] = 16'hB003;
    doReset(1'b0);
    stepTo(28);
    checkOutput("t3_redir_set", {31'h0, bus.o_sqi_redirect}, 32'h1);
    checkOutput("t3_ivld_full", {31'h0, bus.o_instr_vld}, 32'h1);
    checkOutput("t3_head_pc", {16'h0, bus.o_instr_pc}, 32'h0);
    stepTo(30);
    applyStimulus(1'b1, 1'b0, 16'h0);
    runCycles(32);
    checkOutput("t3_redir_clr", {31'h0, bus.o_sqi_redirect}, 32'h0);
    checkOutput("t3_refetch_vld", {31'h0, bus.o_sqi_wr_data_vld}, 32'h1);
    checkOutput("t3_refetch_nib0", {28'h0, bus.o_sqi_wr_data}, 32'h2);
    runCycles(64);
    checkPop("t3_w0", 0, 16'h0000, 16'hB000);
    checkPop("t3_w1", 1, 16'h0001, 16'hB001);
    checkPop("t3_w2", 2, 16'h0002, 16'hB002);
    checkPop("t3_w3", 3, 16'h0003, 16'hB003);

    // Core redirect flushes two buffered words.
    mem[16'h0100] = 16'hC100; mem[16'h0101] = 16'hC101;
    doReset(1'b0);
    stepTo(24);
    checkOutput("t4_ivld_pre", {31'h0, bus.o_instr_vld}, 32'h1);
    stepTo(25);
    applyStimulus(1'b0, 1'b1, 16'h0100);
    stepTo(26);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t4_ivld_flushed", {31'h0, bus.o_instr_vld}, 32'h0);
    checkOutput("t4_redir", {31'h0, bus.o_sqi_redirect}, 32'h1);
    runCycles(30);
    checkOutput("t4_nib2_vld", {31'h0, bus.o_sqi_wr_data_vld}, 32'h1);
    checkOutput("t4_nib2", {28'h0, bus.o_sqi_wr_data}, 32'h1);
    runCycles(60);
    checkPop("t4_w0", 0, 16'h0100, 16'hC100);
    checkPop("t4_w1", 1, 16'h0101, 16'hC101);

    // Redirect during the address phase to the top of the address space.
    mem[16'hFFFF] = 16'hD0FF; mem[0] = 16'hD000;
    doReset(1'b1);
    stepTo(2);
    applyStimulus(1'b1, 1'b1, 16'hFFFF);
    stepTo(3);
    applyStimulus(1'b1, 1'b0, 16'h0);
    checkOutput("t5_nib3", {28'h0, bus.o_sqi_wr_data}, 32'hF);
    checkOutput("t5_redir", {31'h0, bus.o_sqi_redirect}, 32'h1);
    runCycles(44);
    checkPop("t5_w0", 0, 16'hFFFF, 16'hD0FF);
    checkPop("t5_w1", 1, 16'h0000, 16'hD000);

    // Asynchronous reset mid-stream with a full buffer.
    mem[0] = 16'hE000;
    doReset(1'b0);
    stepTo(26);
    checkOutput("t6_ivld_pre", {31'h0, bus.o_instr_vld}, 32'h1);
    #2;
    i_sqi_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ctr", {30'h0, bus.o_sqi_ctr}, 32'h0);
    checkOutput("t6_rst_last", {31'h0, bus.o_sqi_ctr_last_cycle}, 32'h0);
    checkOutput("t6_rst_redir", {31'h0, bus.o_sqi_redirect}, 32'h0);
    checkOutput("t6_rst_rd", {31'h0, bus.o_sqi_rd}, 32'h1);
    checkOutput("t6_rst_wvld", {31'h0, bus.o_sqi_wr_data_vld}, 32'h1);
    checkOutput("t6_rst_ivld", {31'h0, bus.o_instr_vld}, 32'h0);
    checkOutput("t6_rst_instr", {16'h0, bus.o_instr}, 32'h0);
    checkOutput("t6_rst_pc", {16'h0, bus.o_instr_pc}, 32'h0);
    @(negedge i_sqi_gck);
    doReset(1'b1);
    runCycles(24);
    checkPop("t6_w0", 0, 16'h0000, 16'hE000);
    if (pop_cyc.size() >= 1) checkOutput("t6_first_cyc", pop_cyc[0], 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
